image_loader: RTL and testbench

Upstream feeder for `convolution`. It accepts a raster-order 8-bit pixel stream over a valid/ready handshake and assembles 9x9 frames into two ping-pong frame buffers. It then drives `convolution`'s `IMG`/`enable`/`values`/`convolve` inputs for each completed frame and releases the buffer on `done`. Because of the ping-pong buffers, the next frame streams in while the current one is being convolved.

---
 rtl/image_loader_pkg.sv | 14 +
 rtl/image_loader_if.sv | 10 +
 rtl/image_loader_frame_buf.sv | 13 +
 rtl/image_loader.sv | 68 ++++++
 tb/tb_image_loader.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/image_loader_pkg.sv
// image_loader_pkg: frame geometry, derived sizes and drive-side FSM states shared by the image_loader slice
package image_loader_pkg;
    localparam int IMG_W = 9;
    localparam int IMG_H = 9;
    localparam int PIX_W = 8;
    localparam int NPIX = IMG_W * IMG_H;
    localparam int FRAME_BITS = NPIX * PIX_W;
    localparam int IDX_W = $clog2(NPIX);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;
endpackage

// File: rtl/image_loader_if.sv
// image_loader_if: pixel stream s_valid/s_data/s_last from master, s_ready back from slave (the loader)
interface image_loader_if;
    import image_loader_pkg::*;
    logic             s_valid;
    logic [PIX_W-1:0] s_data;
    logic             s_last;
    logic             s_ready;
    modport master (output s_valid, s_data, s_last, input s_ready);
    modport slave (input s_valid, s_data, s_last, output s_ready);
endinterface

// File: rtl/image_loader_frame_buf.sv
// frame_buf: one frame register with indexed pixel write; ports clk, we, idx, din, frame
module frame_buf
    import image_loader_pkg::*;
(
    input  logic                  clk,
    input  logic                  we,
    input  logic [IDX_W-1:0]      idx,
    input  logic [PIX_W-1:0]      din,
    output logic [FRAME_BITS-1:0] frame
);
    always_ff @(posedge clk)
        if (we) frame[idx*PIX_W +: PIX_W] <= din;
endmodule

// File: rtl/image_loader.sv
// image_loader: ping-pong 9x9 frame assembler feeding convolution; ports clk, rst, s (stream slave), IMG/enable/values/convolve/done (convolution side), frame_err
module image_loader
    import image_loader_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    image_loader_if.slave         s,
    output logic [FRAME_BITS-1:0] IMG,
    output logic                  enable,
    output logic                  values,
    output logic                  convolve,
    input  logic                  done,
    output logic                  frame_err
);
    logic [IDX_W-1:0]      idx;
    logic [1:0]            full;
    logic                  wr_sel, rd_sel;
    logic                  hs, at_end, fill_ok, fill_err, release_buf;
    logic [FRAME_BITS-1:0] frames [2];
    state_t                state, state_n;

    assign s.s_ready   = !rst && !full[wr_sel];
    assign hs          = s.s_valid && s.s_ready;
    assign at_end      = idx == IDX_W'(NPIX - 1);
    assign fill_ok     = hs && at_end && s.s_last;
    assign fill_err    = hs && (s.s_last != at_end);
    assign release_buf = state == ST_RUN && done;

    for (genvar i = 0; i < 2; i++) begin : g_buf
        frame_buf u_buf (
            .clk   (clk),
            .we    (hs && wr_sel == 1'(i)),
            .idx   (idx),
            .din   (s.s_data),
            .frame (frames[i])
        );
    end

    // a buffer is only set while empty and only cleared while full, so set/clear never collide
    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= '0;
            full      <= '0;
            wr_sel    <= 1'b0;
            rd_sel    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            idx       <= !hs ? idx : (s.s_last || at_end) ? '0 : idx + 1'b1;
            frame_err <= fill_err;
            wr_sel    <= wr_sel ^ fill_ok;
            rd_sel    <= rd_sel ^ release_buf;
            full      <= (full | (fill_ok ? 2'b01 << wr_sel : 2'b00)) & ~(release_buf ? 2'b01 << rd_sel : 2'b00);
        end
    end

    always_ff @(posedge clk)
        state <= rst ? ST_IDLE : state_n;

    always_comb begin
        state_n  = state == ST_IDLE ? (full[rd_sel] ? ST_LOAD : ST_IDLE) :
                   state == ST_LOAD ? ST_RUN :
                   state == ST_RUN  ? (done ? ST_IDLE : ST_RUN) : ST_IDLE;
        enable   = state == ST_LOAD || state == ST_RUN;
        values   = state == ST_LOAD;
        convolve = state == ST_RUN;
        IMG      = enable ? frames[rd_sel] : '0;
    end
endmodule

// File: tb/tb_image_loader.sv
// tb_image_loader: directed self-checking bench for image_loader
module tb_image_loader;
    import image_loader_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  done = 1'b0;
    logic [FRAME_BITS-1:0] img;
    logic                  enable, values, convolve, frame_err;
    int                    total = 0;
    int                    passed = 0;
    int                    cyc;

    image_loader_if sif ();

    image_loader dut (
        .clk       (clk),
        .rst       (rst),
        .s         (sif.slave),
        .IMG       (img),
        .enable    (enable),
        .values    (values),
        .convolve  (convolve),
        .done      (done),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [FRAME_BITS-1:0] obs, input logic [FRAME_BITS-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [PIX_W-1:0] px(input int i, input int j);
        return img[(i*IMG_W+j)*PIX_W +: PIX_W];
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // kind 0: pixel(i,j) = 3i+j+3, kind 1: pixel = 100 + index
    task automatic send_frame(input int kind, input int n, input int last_at, input bit done_last, output int cycles);
        cycles = 0;
        for (int k = 0; k < n; k++) begin
            sif.s_valid = 1'b1;
            sif.s_data  = kind == 0 ? 8'(3*(k/IMG_W) + (k%IMG_W) + 3) : 8'(100 + k);
            sif.s_last  = k == last_at;
            done        = done_last && k == n - 1;
            for (int w = 0; !sif.s_ready; w++) begin
                if (w == 300) begin
                    $display("FAIL s_ready_wait: got 0 expected 1 within 300 cycles");
                    $fatal(1, "stream stalled");
                end
                tick();
                cycles++;
            end
            tick();
            cycles++;
        end
        sif.s_valid = 1'b0;
        sif.s_last  = 1'b0;
        done        = 1'b0;
    endtask

    initial begin
        sif.s_valid = 1'b0;
        sif.s_data  = '0;
        sif.s_last  = 1'b0;
        tick(2);
        check("rst_s_ready", sif.s_ready, 0);
        check("rst_enable", enable, 0);
        check("rst_values", values, 0);
        check("rst_convolve", convolve, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_img", img, 0);
        rst = 1'b0;
        #1;
        check("post_rst_s_ready", sif.s_ready, 1);

        // single frame
        send_frame(0, 81, 80, 0, cyc);
        check("a_cycles", cyc, 81);
        check("a_n1_values", values, 0);
        check("a_n1_enable", enable, 0);
        tick();
        check("a_n2_values", values, 1);
        check("a_n2_enable", enable, 1);
        check("a_n2_convolve", convolve, 0);
        check("a_px_2_4", px(2, 4), 13);
        check("a_px_8_8", px(8, 8), 35);
        tick();
        check("a_n3_convolve", convolve, 1);
        check("a_n3_values", values, 0);
        tick(5);
        check("a_hold_convolve", convolve, 1);
        done = 1'b1;
        tick();
        done = 1'b0;
        check("a_rel_convolve", convolve, 0);
        check("a_rel_enable", enable, 0);
        check("a_rel_img", img, 0);

        // ping-pong with done withheld
        send_frame(0, 81, 80, 0, cyc);
        send_frame(1, 81, 80, 0, cyc);
        check("pp_b_cycles", cyc, 81);
        check("pp_both_full_ready", sif.s_ready, 0);
        check("pp_a_convolve", convolve, 1);
        check("pp_a_px_0_0", px(0, 0), 3);
        tick(3);
        check("pp_still_blocked", sif.s_ready, 0);
        done = 1'b1;
        tick();
        done = 1'b0;
        check("pp_rel_ready", sif.s_ready, 1);
        check("pp_rel_convolve", convolve, 0);
        tick();
        check("pp_b_values", values, 1);
        check("pp_b_px_0_0", px(0, 0), 100);
        check("pp_b_px_8_8", px(8, 8), 180);
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        check("pp_b_rel_enable", enable, 0);

        // early last
        send_frame(0, 41, 40, 0, cyc);
        check("early_err", frame_err, 1);
        tick();
        check("early_err_once", frame_err, 0);
        tick(4);
        check("early_no_load", enable, 0);
        check("early_ready", sif.s_ready, 1);
        send_frame(1, 81, 80, 0, cyc);
        check("early_next_err", frame_err, 0);
        tick();
        check("early_next_values", values, 1);
        check("early_next_px_8_8", px(8, 8), 180);
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;

        // missing last
        send_frame(0, 81, -1, 0, cyc);
        check("miss_err", frame_err, 1);
        tick();
        check("miss_err_once", frame_err, 0);
        tick(4);
        check("miss_no_load", enable, 0);

        // reset mid-RUN with the other buffer full
        send_frame(0, 81, 80, 0, cyc);
        send_frame(1, 81, 80, 0, cyc);
        check("mr_running", convolve, 1);
        check("mr_blocked", sif.s_ready, 0);
        rst = 1'b1;
        #1;
        check("mr_rst_ready", sif.s_ready, 0);
        tick();
        check("mr_enable", enable, 0);
        check("mr_values", values, 0);
        check("mr_convolve", convolve, 0);
        check("mr_img", img, 0);
        check("mr_frame_err", frame_err, 0);
        rst = 1'b0;
        #1;
        check("mr_ready", sif.s_ready, 1);
        tick(5);
        check("mr_no_load_values", values, 0);
        check("mr_no_load_enable", enable, 0);
        send_frame(1, 81, 80, 0, cyc);
        tick();
        check("mr_new_values", values, 1);
        check("mr_new_px_0_0", px(0, 0), 100);
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;

        // fill completion and release in the same cycle
        send_frame(0, 81, 80, 0, cyc);
        send_frame(1, 81, 80, 1, cyc);
        check("sim_frame_err", frame_err, 0);
        check("sim_a_released", convolve, 0);
        check("sim_n1_values", values, 0);
        check("sim_ready", sif.s_ready, 1);
        tick();
        check("sim_b_values", values, 1);
        check("sim_b_px_0_0", px(0, 0), 100);
        tick();
        check("sim_b_convolve", convolve, 1);
        check("sim_frame_err_quiet", frame_err, 0);
        done = 1'b1;
        tick();
        done = 1'b0;
        check("sim_end_enable", enable, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
